exec_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the execute stage (register file + ALU). Accepts one 32-bit RV32I instruction through a valid/ready handshake, decodes it, and drives the execute stage's control and operand-select inputs through DECODE, EXEC and WB cycles. Supports R-type ALU, I-type ALU and BEQ/BNE branches, and flags everything else as illegal. Sits between instruction fetch and `execute`.

---
 rtl/exec_seq_pkg.sv | 36 +++
 rtl/instr_decoder.sv | 63 ++++++
 rtl/exec_sequencer.sv | 137 +++++++++++++
 tb/tb_exec_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_seq_pkg.sv
// Shared constants, state encoding and decoded-field bundle for exec_sequencer.
// Optional feature macro used by the top: EXEC_SEQ_RETIRE_CNT_EN.
package exec_seq_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [1:0]  alu_op;
        logic        alu_src;
        logic [31:0] imm;
        logic        writes_rd;
        logic        is_branch;
    } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder for the R-type ALU, I-type ALU and BEQ/BNE subset;
// everything outside that subset raises illegal.
module instr_decoder
    import exec_seq_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    // NOTE: every output is given a default before the case so no path can infer a latch.
    always_comb begin
        dec           = '0;
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.rd        = instr[11:7];
        dec.funct3    = f3;
        dec.alu_op    = ALU_ADD;
        illegal       = 1'b0;

        case (opcode)
            OP_R: begin
                dec.alu_op    = ALU_FUNCT;
                dec.funct7    = f7;
                dec.writes_rd = 1'b1;
                if (!((f7 == F7_BASE) ||
                      ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))))
                    illegal = 1'b1;
            end
            OP_I: begin
                dec.alu_op    = ALU_FUNCT;
                dec.alu_src   = 1'b1;
                dec.imm       = {{20{instr[31]}}, instr[31:20]};
                dec.rs2       = 5'd0;
                dec.writes_rd = 1'b1;
                // Only shift-right immediates forward the upper bits, to pick SRLI vs SRAI.
                if (f3 == 3'b101) begin
                    dec.funct7 = f7;
                    if ((f7 != F7_BASE) && (f7 != F7_ALT))
                        illegal = 1'b1;
                end else if ((f3 == 3'b001) && (f7 != F7_BASE)) begin
                    illegal = 1'b1;
                end
            end
            OP_B: begin
                dec.alu_op    = ALU_BR;
                dec.is_branch = 1'b1;
                if (f3[2:1] != 2'b00)
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Four-state sequencer (IDLE/DECODE/EXEC/WB) driving the execute stage for one instruction.
// Define EXEC_SEQ_RETIRE_CNT_EN to add the 32-bit retire_cnt output.
module exec_sequencer
    import exec_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        zero,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [1:0]  alu_op,
    output logic        alu_src,
    output logic [31:0] imm,
    output logic        we,
    output logic        branch_taken,
    output logic        done,
`ifdef EXEC_SEQ_RETIRE_CNT_EN
    output logic [31:0] retire_cnt,
`endif
    output logic        illegal
);

    state_t      state;
    state_t      state_next;
    logic [31:0] instr_q;
    dec_t        dec;
    logic        dec_illegal;
    logic        writes_rd_q;
    logic        is_branch_q;

    instr_decoder u_decoder (
        .instr   (instr_q),
        .dec     (dec),
        .illegal (dec_illegal)
    );

    // NOTE: state and data registers use non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        illegal     = 1'b0;
        done        = 1'b0;
        we          = 1'b0;

        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    illegal    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: state_next = S_WB;
            S_WB: begin
                done       = 1'b1;
                we         = writes_rd_q && (rd != 5'd0);
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // An aborted instruction must not produce any strobe in the reset cycle.
        if (reset) begin
            instr_ready = 1'b0;
            illegal     = 1'b0;
            done        = 1'b0;
            we          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q      <= '0;
            rs1          <= '0;
            rs2          <= '0;
            rd           <= '0;
            funct3       <= '0;
            funct7       <= '0;
            alu_op       <= ALU_ADD;
            alu_src      <= 1'b0;
            imm          <= '0;
            writes_rd_q  <= 1'b0;
            is_branch_q  <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            if ((state == S_IDLE) && instr_valid)
                instr_q <= instr;

            if (state == S_DECODE) begin
                rs1          <= dec.rs1;
                rs2          <= dec.rs2;
                rd           <= dec.rd;
                funct3       <= dec.funct3;
                funct7       <= dec.funct7;
                alu_op       <= dec.alu_op;
                alu_src      <= dec.alu_src;
                imm          <= dec.imm;
                writes_rd_q  <= dec.writes_rd;
                is_branch_q  <= dec.is_branch;
                branch_taken <= 1'b0;
            end

            // zero reflects rs1 - rs2 once the ALU has settled in EXEC; funct3[0] selects BNE.
            if ((state == S_EXEC) && is_branch_q)
                branch_taken <= funct3[0] ? ~zero : zero;
        end
    end

`ifdef EXEC_SEQ_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            retire_cnt <= '0;
        else if (state == S_WB)
            retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed cases plus random RV32I words,
// with a behavioural register file standing in for the execute stage.
`timescale 1ns/1ps
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        zero;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [31:0] imm;
    logic        we, branch_taken, done, illegal;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int retired = 0;

    // rf: register file written through the DUT's control outputs.
    // ref_rf: the same registers updated straight from instruction semantics.
    logic [31:0] rf     [32];
    logic [31:0] ref_rf [32];

    exec_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .zero         (zero),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .funct3       (funct3),
        .funct7       (funct7),
        .alu_op       (alu_op),
        .alu_src      (alu_src),
        .imm          (imm),
        .we           (we),
        .branch_taken (branch_taken),
        .done         (done),
`ifdef EXEC_SEQ_RETIRE_CNT_EN
        .retire_cnt   (retire_cnt),
`endif
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    assign zero = ((rf[rs1] - (alu_src ? imm : rf[rs2])) == 32'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rv_alu(input logic [2:0] f3, input bit alt,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = {31'd0, $signed(a) < $signed(b)};
            3'd3: r = {31'd0, a < b};
            3'd4: r = a ^ b;
            3'd5: begin
                if (alt) r = $signed(a) >>> b[4:0];
                else     r = a >> b[4:0];
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // The execute stage as it would react to the DUT's control outputs.
    function automatic logic [31:0] exec_result();
        logic [31:0] a = rf[rs1];
        logic [31:0] b = alu_src ? imm : rf[rs2];
        if (alu_op == 2'b00) return a + b;
        if (alu_op == 2'b01) return a - b;
        return rv_alu(funct3, funct7[5], a, b);
    endfunction

    function automatic bit ref_legal(input logic [31:0] w);
        logic [6:0] f7 = w[31:25];
        logic [2:0] f3 = w[14:12];
        case (w[6:0])
            7'b0110011: return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            7'b0010011: begin
                if (f3 == 3'd1) return f7 == 7'h00;
                if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
                return 1'b1;
            end
            7'b1100011: return (f3 == 3'd0) || (f3 == 3'd1);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 9);
        int p = $urandom_range(0, 3);
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        w[11:7]  = 5'($urandom_range(0, 7));
        if (k < 3) begin
            w[6:0] = 7'b0110011;
            if (p < 2) w[31:25] = 7'h00; else if (p == 2) w[31:25] = 7'h20;
        end else if (k < 6) begin
            w[6:0] = 7'b0010011;
            if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
                if (p < 2) w[31:25] = 7'h00; else if (p == 2) w[31:25] = 7'h20;
            end
        end else if (k < 8) begin
            w[6:0] = 7'b1100011;
            if (p != 3) w[14:12] = 3'($urandom_range(0, 1));
            if (p[0]) w[24:20] = w[19:15];
        end
        return w;
    endfunction

    // Issue one instruction starting mid-cycle in IDLE; returns mid-cycle of the next IDLE.
    task automatic run(input logic [31:0] w, input bit keep, input logic [31:0] nxt);
        bit          legal = ref_legal(w);
        bit          is_r  = (w[6:0] == 7'b0110011);
        bit          is_i  = (w[6:0] == 7'b0010011);
        bit          is_b  = (w[6:0] == 7'b1100011);
        logic [2:0]  f3    = w[14:12];
        logic [4:0]  wrd   = w[11:7];
        logic [31:0] a     = ref_rf[w[19:15]];
        logic [31:0] b     = ref_rf[w[24:20]];
        logic [31:0] iimm  = {{20{w[31]}}, w[31:20]};
        logic [31:0] res;
        bit          exp_bt = (f3 == 3'd0) ? (a == b) : (a != b);
        bit          exp_we = (is_r || is_i) && (wrd != 5'd0);

        res = is_r ? rv_alu(f3, w[30], a, b) : rv_alu(f3, (f3 == 3'd5) && w[30], a, iimm);

        check("ready_idle", instr_ready, 1'b1);
        instr_valid = 1'b1;
        instr       = w;

        @(negedge clk);
        if (keep) instr = nxt;
        else begin
            instr_valid = 1'b0;
            instr       = $urandom;
        end
        check("ready_decode", instr_ready, 1'b0);
        check("illegal_decode", illegal, !legal);
        check("we_decode", we, 1'b0);
        check("done_decode", done, 1'b0);

        if (!legal) begin
            @(negedge clk);
            check("ready_after_illegal", instr_ready, 1'b1);
            check("illegal_pulse_end", illegal, 1'b0);
            check("we_after_illegal", we, 1'b0);
            check("done_after_illegal", done, 1'b0);
            return;
        end

        @(negedge clk);
        check("rs1", rs1, w[19:15]);
        check("rs2", rs2, is_i ? 5'd0 : w[24:20]);
        check("funct3", funct3, f3);
        check("alu_op", alu_op, is_b ? 2'b01 : 2'b10);
        check("alu_src", alu_src, is_i);
        if (!is_b) check("rd", rd, wrd);
        if (is_r) check("funct7_r", funct7, w[31:25]);
        if (is_i) begin
            check("funct7_i", funct7, (f3 == 3'd5) ? w[31:25] : 7'd0);
            check("imm", imm, iimm);
        end
        check("branch_cleared", branch_taken, 1'b0);
        check("we_exec", we, 1'b0);
        check("done_exec", done, 1'b0);

        @(negedge clk);
        check("done_wb", done, 1'b1);
        check("we_wb", we, exp_we);
        check("ready_wb", instr_ready, 1'b0);
        check("illegal_wb", illegal, 1'b0);
        if (is_b) check("branch_taken", branch_taken, exp_bt);
        if (we) rf[rd] = exec_result();
        if (exp_we) ref_rf[wrd] = res;
        retired++;

        @(negedge clk);
        check("ready_again", instr_ready, 1'b1);
        check("done_end", done, 1'b0);
        check("we_end", we, 1'b0);
        check("rd_value", rf[wrd], ref_rf[wrd]);
        check("x0_value", rf[0], 32'd0);
`ifdef EXEC_SEQ_RETIRE_CNT_EN
        check("retire_cnt", retire_cnt, retired);
`endif
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] nxt;

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        for (int i = 0; i < 32; i++) begin
            rf[i]     = (i == 0) ? 32'd0 : $urandom;
            ref_rf[i] = rf[i];
        end
        rf[1] = 32'd10; ref_rf[1] = 32'd10;
        rf[2] = 32'd15; ref_rf[2] = 32'd15;

        @(negedge clk);
        @(negedge clk);
        check("reset_ready", instr_ready, 1'b0);
        check("reset_we", we, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_illegal", illegal, 1'b0);
        check("reset_fields", {rs1, rs2, rd, funct3, funct7, alu_op, alu_src}, 32'd0);
        check("reset_imm", imm, 32'd0);
        check("reset_branch", branch_taken, 1'b0);
`ifdef EXEC_SEQ_RETIRE_CNT_EN
        check("reset_retire_cnt", retire_cnt, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        run(32'h002082b3, 1'b0, 32'd0);
        check("add_x5", rf[5], 32'd25);
        run(32'hffd08313, 1'b0, 32'd0);
        check("addi_x6", rf[6], 32'd7);
        rf[1] = 32'hFFFFFFF0; ref_rf[1] = 32'hFFFFFFF0;
        run(32'h4020d393, 1'b0, 32'd0);
        check("srai_x7", rf[7], 32'hFFFFFFFC);
        run(32'h00108463, 1'b0, 32'd0);
        run(32'h00109463, 1'b0, 32'd0);
        run(32'h0000007f, 1'b0, 32'd0);
        run(32'h00208033, 1'b0, 32'd0);

        // Abort an add in EXEC.
        instr_valid = 1'b1;
        instr       = 32'h002082b3;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready_in_reset", instr_ready, 1'b0);
        check("abort_we", we, 1'b0);
        check("abort_done", done, 1'b0);
        reset   = 1'b0;
        retired = 0;
        @(negedge clk);
        check("abort_ready", instr_ready, 1'b1);
        check("abort_done_after", done, 1'b0);
        check("abort_we_after", we, 1'b0);
        check("abort_x5_kept", rf[5], ref_rf[5]);
        @(negedge clk);
        check("abort_no_late_done", done, 1'b0);

        // Back-to-back with instr_valid held high.
        run(32'h002082b3, 1'b1, 32'hffd08313);
        run(32'hffd08313, 1'b1, 32'h00108463);
        run(32'h00108463, 1'b0, 32'd0);
`ifdef EXEC_SEQ_RETIRE_CNT_EN
        check("retire_cnt_three", retire_cnt, 32'd3);
`endif

        w = gen();
        for (int n = 0; n < 60; n++) begin
            nxt = gen();
            run(w, 1'($urandom_range(0, 1)), nxt);
            w = nxt;
        end
        instr_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
